id_control_stage: RTL and testbench

Instruction-decode control stage with integrated ID/EX control register and load-use hazard detection. Decodes the IF/ID instruction into the main control word, including the 4-bit ALUOp consumed by the EX-stage ALU control decoder. The result is registered into the ID/EX boundary. Sits between the IF/ID register and the execution datapath, and drives the stall line back to the PC and IF/ID.

---
 rtl/id_control_pkg.sv | 53 +++++
 rtl/id_control_stage_main_decoder.sv | 72 +++++++
 rtl/id_control_stage.sv | 96 +++++++++
 tb/tb_id_control_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/id_control_pkg.sv
// Shared opcodes, ALUOp classes and ID/EX bundle layout
// for the decode control stage and the EX-stage ALU control.
package id_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALUOP_RTYPE  = 4'b0000;
  localparam logic [3:0] ALUOP_MEM    = 4'b0001;
  localparam logic [3:0] ALUOP_BRANCH = 4'b0010;
  localparam logic       ALUOP_IMM    = 1'b1;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       zero_ext;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       link;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } id_ex_t;

endpackage

// File: rtl/id_control_stage_main_decoder.sv
// Combinational main decoder: opcode to control word,
// plus the rt-as-source flag used by hazard detection.
module main_decoder
  import id_control_pkg::*;
(
  input  logic [31:0] i_instruction,
  output ctrl_t       o_ctrl,
  output logic        o_uses_rt,
  output logic        o_illegal
);

  logic [5:0] op;
  logic is_r, is_ld, is_st, is_imm, is_br, is_j, is_jal;

  assign op     = i_instruction[31:26];
  assign is_r   = (op == OP_RTYPE);
  assign is_ld  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_st  = op inside {OP_SB, OP_SH, OP_SW};
  assign is_imm = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                             OP_ORI, OP_XORI, OP_LUI};
  assign is_br  = op inside {OP_BEQ, OP_BNE};
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);

  always_comb begin
    o_ctrl    = '0;
    o_uses_rt = 1'b0;
    o_illegal = 1'b0;
    unique case (1'b1)
      is_r: begin
        o_ctrl.alu_op    = ALUOP_RTYPE;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = (i_instruction != 32'd0);
        o_uses_rt        = 1'b1;
      end
      is_ld: begin
        o_ctrl.alu_op     = ALUOP_MEM;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      is_st: begin
        o_ctrl.alu_op    = ALUOP_MEM;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_uses_rt        = 1'b1;
      end
      is_imm: begin
        o_ctrl.alu_op    = (op == OP_ADDIU) ? {ALUOP_IMM, 3'b000}
                                            : {ALUOP_IMM, op[2:0]};
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.zero_ext  = op[2] & ~(op[1] & op[0]);
      end
      is_br: begin
        o_ctrl.alu_op = ALUOP_BRANCH;
        o_uses_rt     = 1'b1;
      end
      is_j: begin
        o_ctrl.alu_op = ALUOP_BRANCH;
      end
      is_jal: begin
        o_ctrl.alu_op    = ALUOP_BRANCH;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.link      = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_control_stage.sv
// ID control stage: main decode, ID/EX control register,
// load-use stall and sticky illegal-opcode flag.
module id_control_stage
  import id_control_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_instruction,
  input  logic        i_valid,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_valid,
  output logic [3:0]  o_ALUOp,
  output logic [5:0]  o_funct,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [15:0] o_imm,
  output logic        o_zero_ext,
  output logic        o_ALUSrc,
  output logic        o_RegDst,
  output logic        o_RegWrite,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_MemtoReg,
  output logic        o_link,
  output logic        o_illegal
);

  ctrl_t      dec;
  logic       uses_rt, dec_illegal;
  logic       hazard, load;
  logic [4:0] rs, rt, rd;
  id_ex_t     ex_d, ex_q;
  logic       illegal_d, illegal_q;

  assign rs = i_instruction[25:21];
  assign rt = i_instruction[20:16];
  assign rd = i_instruction[15:11];

  main_decoder u_dec (
    .i_instruction (i_instruction),
    .o_ctrl        (dec),
    .o_uses_rt     (uses_rt),
    .o_illegal     (dec_illegal)
  );

  // Only the load in EX can create a dependency not covered by forwarding.
  assign hazard = ex_q.valid & ex_q.ctrl.mem_read
                & (ex_q.rt != 5'd0) & i_valid
                & ((ex_q.rt == rs) | (uses_rt & (ex_q.rt == rt)));
  assign o_stall = hazard & ~i_flush;
  assign load    = i_valid & ~i_flush & ~hazard;

  always_comb begin
    ex_d      = '0;
    illegal_d = illegal_q | (load & dec_illegal);
    if (load && !dec_illegal) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = dec;
      ex_d.funct = i_instruction[5:0];
      ex_d.rs    = rs;
      ex_d.rt    = rt;
      ex_d.rd    = dec.link ? 5'd31 : rd;
      ex_d.imm   = i_instruction[15:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_valid    = ex_q.valid;
  assign o_ALUOp    = ex_q.ctrl.alu_op;
  assign o_funct    = ex_q.funct;
  assign o_rs       = ex_q.rs;
  assign o_rt       = ex_q.rt;
  assign o_rd       = ex_q.rd;
  assign o_imm      = ex_q.imm;
  assign o_zero_ext = ex_q.ctrl.zero_ext;
  assign o_ALUSrc   = ex_q.ctrl.alu_src;
  assign o_RegDst   = ex_q.ctrl.reg_dst;
  assign o_RegWrite = ex_q.ctrl.reg_write;
  assign o_MemRead  = ex_q.ctrl.mem_read;
  assign o_MemWrite = ex_q.ctrl.mem_write;
  assign o_MemtoReg = ex_q.ctrl.mem_to_reg;
  assign o_link     = ex_q.ctrl.link;
  assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_id_control_stage.sv
// Directed scoreboard bench for id_control_stage.
// Driver queues expectations; a monitor checks each cycle.
module tb_id_control_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        vld, flush;
  logic        stall, ovld;
  logic [3:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        ze, src, dst, wr, mr, mw, m2r, lnk, ill;

  always #5 clk = ~clk;

  id_control_stage dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_instruction (instr),
    .i_valid       (vld),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_valid       (ovld),
    .o_ALUOp       (aluop),
    .o_funct       (funct),
    .o_rs          (rs),
    .o_rt          (rt),
    .o_rd          (rd),
    .o_imm         (imm),
    .o_zero_ext    (ze),
    .o_ALUSrc      (src),
    .o_RegDst      (dst),
    .o_RegWrite    (wr),
    .o_MemRead     (mr),
    .o_MemWrite    (mw),
    .o_MemtoReg    (m2r),
    .o_link        (lnk),
    .o_illegal     (ill)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [7:0]  ctl;
    logic        ill;
  } out_t;

  typedef struct packed {
    logic stall;
    out_t out;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   drv_done = 0;

  localparam logic [31:0] ADD1  = 32'h0043_0820;
  localparam logic [31:0] LW2   = 32'h8C22_0004;
  localparam logic [31:0] ADD3  = 32'h0042_1820;
  localparam logic [31:0] LW4   = 32'h8C64_0008;
  localparam logic [31:0] LW0   = 32'h8C20_0000;
  localparam logic [31:0] ADD00 = 32'h0000_1820;
  localparam logic [31:0] SW2   = 32'hACA2_0000;
  localparam logic [31:0] ORI   = 32'h3405_FFFF;
  localparam logic [31:0] JAL   = 32'h0C00_0010;
  localparam logic [31:0] SLTIU = 32'h2C00_0000;

  // ctl = {ze, src, dst, wr, mr, mw, m2r, link}
  function automatic out_t bub(input logic i);
    out_t o;
    o = '0;
    o.ill = i;
    return o;
  endfunction

  function automatic out_t mk(input logic [3:0] a,
                              input logic [5:0] f,
                              input logic [4:0] s, t, d,
                              input logic [15:0] m,
                              input logic [7:0] c,
                              input logic i);
    out_t o;
    o.valid = 1'b1;
    o.alu = a;
    o.funct = f;
    o.rs = s;
    o.rt = t;
    o.rd = d;
    o.imm = m;
    o.ctl = c;
    o.ill = i;
    return o;
  endfunction

  out_t e_add1, e_lw2, e_add3, e_lw4, e_lw0, e_add00;
  out_t e_sw2, e_ori, e_jal, e_nop;

  task automatic step(input logic r, input logic [31:0] in,
                      input logic v, input logic f,
                      input logic es, input out_t eo);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    instr = in;
    vld = v;
    flush = f;
    e.stall = es;
    e.out = eo;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    out_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {ovld, aluop, funct, rs, rt, rd, imm,
           {ze, src, dst, wr, mr, mw, m2r, lnk}, ill};
      n_chk++;
      if (stall !== e.stall) begin
        n_fail++;
        $display("FAIL stall t=%0t got %b want %b",
                 $time, stall, e.stall);
      end
      n_chk++;
      if (a !== e.out) begin
        n_fail++;
        $display("FAIL idex t=%0t got %h want %h",
                 $time, a, e.out);
      end
    end
  end

  initial begin
    e_add1  = mk(4'b0000, 6'h20, 5'd2, 5'd3, 5'd1, 16'h0820,
                 8'b0011_0000, 1'b0);
    e_lw2   = mk(4'b0001, 6'h04, 5'd1, 5'd2, 5'd0, 16'h0004,
                 8'b0101_1010, 1'b0);
    e_add3  = mk(4'b0000, 6'h20, 5'd2, 5'd2, 5'd3, 16'h1820,
                 8'b0011_0000, 1'b0);
    e_lw4   = mk(4'b0001, 6'h08, 5'd3, 5'd4, 5'd0, 16'h0008,
                 8'b0101_1010, 1'b0);
    e_lw0   = mk(4'b0001, 6'h00, 5'd1, 5'd0, 5'd0, 16'h0000,
                 8'b0101_1010, 1'b0);
    e_add00 = mk(4'b0000, 6'h20, 5'd0, 5'd0, 5'd3, 16'h1820,
                 8'b0011_0000, 1'b0);
    e_sw2   = mk(4'b0001, 6'h00, 5'd5, 5'd2, 5'd0, 16'h0000,
                 8'b0100_0100, 1'b0);
    e_ori   = mk(4'b1101, 6'h3F, 5'd0, 5'd5, 5'd31, 16'hFFFF,
                 8'b1101_0000, 1'b0);
    e_jal   = mk(4'b0010, 6'h10, 5'd0, 5'd0, 5'd31, 16'h0010,
                 8'b0001_0001, 1'b0);
    e_nop   = mk(4'b0000, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0000,
                 8'b0010_0000, 1'b0);

    rst = 1'b1;
    instr = '0;
    vld = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);

    step(0, 32'd0, 0, 0, 0, bub(0));
    step(0, ADD1,  1, 0, 0, bub(0));
    step(0, LW2,   1, 0, 0, e_add1);
    step(0, ADD3,  1, 0, 1, e_lw2);
    step(0, ADD3,  1, 0, 0, bub(0));
    step(0, LW2,   1, 0, 0, e_add3);
    step(0, ADD3,  1, 1, 0, e_lw2);
    step(0, 32'd0, 0, 0, 0, bub(0));
    step(0, LW2,   1, 0, 0, bub(0));
    step(0, LW4,   1, 0, 0, e_lw2);
    step(0, LW0,   1, 0, 0, e_lw4);
    step(0, ADD00, 1, 0, 0, e_lw0);
    step(0, LW2,   1, 0, 0, e_add00);
    step(0, SW2,   1, 0, 1, e_lw2);
    step(0, SW2,   1, 0, 0, bub(0));
    step(0, ORI,   1, 0, 0, e_sw2);
    step(0, JAL,   1, 0, 0, e_ori);
    step(0, 32'd0, 1, 0, 0, e_jal);
    step(0, SLTIU, 1, 0, 0, e_nop);
    e_add1.ill = 1'b1;
    e_lw2.ill  = 1'b1;
    step(0, ADD1,  1, 0, 0, bub(1));
    step(0, LW2,   1, 0, 0, e_add1);
    step(1, ADD3,  1, 0, 1, e_lw2);
    step(0, ADD3,  1, 0, 0, bub(0));
    step(0, 32'd0, 0, 0, 0, e_add3);
    drv_done = 1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!drv_done && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (!drv_done || q.size() != 0) begin
      n_fail++;
      $display("FAIL drain done=%0d left %0d want 0",
               drv_done, q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
